// File: rtl/ppu_bg_serializer.sv
// Background pixel serializer: stages fetched tile bytes, reloads them into 16-bit pattern
// and 8-bit attribute shifters on tile boundaries, and emits one fine-X-selected pixel per dot.
module ppu_bg_serializer #(
  parameter int unsigned RELOAD_PHASE = 7
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_shift,
  input  logic       i_sync,
  input  logic       i_pat_lo_load,
  input  logic [7:0] i_pat_lo,
  input  logic       i_pat_hi_load,
  input  logic [7:0] i_pat_hi,
  input  logic       i_attr_load,
  input  logic [1:0] i_attr,
  input  logic [2:0] i_fine_x,
  input  logic       i_clear_underrun,
  output logic [1:0] o_pixel,
  output logic [1:0] o_palette,
  output logic       o_stage_full,
  output logic       o_underrun,
  output logic [2:0] o_debug_phase
);

  logic [7:0]  stage_lo, stage_hi;
  logic [1:0]  stage_attr;
  logic        vld_lo, vld_hi, vld_attr;
  logic [15:0] shift_lo, shift_hi;
  logic [7:0]  attr_lo, attr_hi;
  logic        latch_lo, latch_hi;
  logic [2:0]  phase;
  logic        underrun;
  logic        stage_full;
  logic        reload;
  logic [3:0]  pix_idx;
  logic [2:0]  pal_idx;

  assign stage_full = vld_lo & vld_hi & vld_attr;
  assign reload     = i_shift && (phase == 3'(RELOAD_PHASE));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stage_lo   <= '0;
      stage_hi   <= '0;
      stage_attr <= '0;
      vld_lo     <= 1'b0;
      vld_hi     <= 1'b0;
      vld_attr   <= 1'b0;
      shift_lo   <= '0;
      shift_hi   <= '0;
      attr_lo    <= '0;
      attr_hi    <= '0;
      latch_lo   <= 1'b0;
      latch_hi   <= 1'b0;
      phase      <= '0;
      underrun   <= 1'b0;
    end else begin
      // On a reload edge the shifted upper byte is kept and the staged byte fills the lower one.
      if (i_shift) begin
        if (reload) begin
          shift_lo <= {shift_lo[14:7], stage_lo};
          shift_hi <= {shift_hi[14:7], stage_hi};
        end else begin
          shift_lo <= {shift_lo[14:0], 1'b0};
          shift_hi <= {shift_hi[14:0], 1'b0};
        end
        attr_lo <= {attr_lo[6:0], latch_lo};
        attr_hi <= {attr_hi[6:0], latch_hi};
      end

      if (reload) begin
        latch_lo <= stage_attr[0];
        latch_hi <= stage_attr[1];
      end

      // A capture on the reload edge keeps its valid flag: set wins over clear.
      if (i_pat_lo_load) begin
        stage_lo <= i_pat_lo;
        vld_lo   <= 1'b1;
      end else if (reload) begin
        vld_lo <= 1'b0;
      end

      if (i_pat_hi_load) begin
        stage_hi <= i_pat_hi;
        vld_hi   <= 1'b1;
      end else if (reload) begin
        vld_hi <= 1'b0;
      end

      if (i_attr_load) begin
        stage_attr <= i_attr;
        vld_attr   <= 1'b1;
      end else if (reload) begin
        vld_attr <= 1'b0;
      end

      if (reload && !stage_full) begin
        underrun <= 1'b1;
      end else if (i_clear_underrun) begin
        underrun <= 1'b0;
      end

      if (i_sync) begin
        phase <= '0;
      end else if (i_shift) begin
        phase <= phase + 3'd1;
      end
    end
  end

  assign pix_idx = 4'd15 - {1'b0, i_fine_x};
  assign pal_idx = 3'd7 - i_fine_x;

  assign o_pixel       = {shift_hi[pix_idx], shift_lo[pix_idx]};
  assign o_palette     = {attr_hi[pal_idx], attr_lo[pal_idx]};
  assign o_stage_full  = stage_full;
  assign o_underrun    = underrun;
  assign o_debug_phase = phase;

endmodule
